dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_arb_sel.sv | 55 +++++
 rtl/dmem_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Optional feature macro: DMEM_ARB_RR_EN (round-robin arbitration).
package dmem_arb_pkg;

   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CPU_RD = 2'd1,
      EXT_RD = 2'd2
   } dmem_arb_state_t;

   typedef enum logic {
      GNT_CPU = 1'b0,
      GNT_EXT = 1'b1
   } dmem_grant_t;

endpackage

// File: rtl/dmem_arb_sel.sv
// Combinational grant selection between the CPU and the external port.
// Optional feature macro: DMEM_ARB_RR_EN (round-robin instead of priority).
module dmem_arb_sel
   import dmem_arb_pkg::*;
`ifndef DMEM_ARB_RR_EN
#(
   parameter int MAX_WAIT = 8,
   parameter int CW       = 4
)
`endif
(
   input  logic              cpuReq,
   input  logic              extReq,
`ifdef DMEM_ARB_RR_EN
   input  dmem_grant_t       lastGnt,
`else
   input  logic [CW-1:0]     waitCnt,
`endif
   output logic              gntCpu,
   output logic              gntExt
);

`ifdef DMEM_ARB_RR_EN
   // On contention serve whichever side was not served last.
   always_comb begin
      gntCpu = 1'b0;
      gntExt = 1'b0;
      unique case ({cpuReq, extReq})
         2'b11: begin
            if (lastGnt == GNT_CPU) gntExt = 1'b1;
            else                    gntCpu = 1'b1;
         end
         2'b10: gntCpu = 1'b1;
         2'b01: gntExt = 1'b1;
         default: ;
      endcase
   end
`else
   // CPU wins contention unless ext has waited MAX_WAIT cycles.
   always_comb begin
      gntCpu = 1'b0;
      gntExt = 1'b0;
      unique case ({cpuReq, extReq})
         2'b11: begin
            if (waitCnt == CW'(MAX_WAIT)) gntExt = 1'b1;
            else                          gntCpu = 1'b1;
         end
         2'b10: gntCpu = 1'b1;
         2'b01: gntExt = 1'b1;
         default: ;
      endcase
   end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU MEM stage vs. loader/debug port on one sync RAM.
// Optional feature macro: DMEM_ARB_RR_EN (round-robin arbitration).
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW       = 10,
   parameter int MAX_WAIT = 8
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [15:0]       cpu_addr,
   input  logic [15:0]       cpu_wdata,
   output logic [15:0]       cpu_rdata,
   output logic              cpu_stall,
   input  logic              ext_valid,
   input  logic              ext_we,
   input  logic [15:0]       ext_addr,
   input  logic [15:0]       ext_wdata,
   output logic              ext_ready,
   output logic [15:0]       ext_rdata,
   output logic              ext_rvalid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic [15:0]       mem_rdata
);

   dmem_arb_state_t     state;
   dmem_arb_state_t     stateNext;
   logic                isIdle;
   logic                cpuReqI;
   logic                extReqI;
   logic                gntCpu;
   logic                gntExt;
   logic [DATA_W-1:0]   selAddr;
   logic [DATA_W-1:0]   cpuRdataQ;
   logic [DATA_W-1:0]   extRdataQ;
   logic                unusedAddrBits;

   // Requests only compete while idle and out of reset.
   assign isIdle  = (state == IDLE);
   assign cpuReqI = rst && isIdle && cpu_req;
   assign extReqI = rst && isIdle && ext_valid;

`ifdef DMEM_ARB_RR_EN
   dmem_grant_t lastGnt;

   dmem_arb_sel uSel (
      .cpuReq  (cpuReqI),
      .extReq  (extReqI),
      .lastGnt (lastGnt),
      .gntCpu  (gntCpu),
      .gntExt  (gntExt)
   );

   // Remember who was served last for the next contention.
   always_ff @(posedge clk) begin
      if (!rst)        lastGnt <= GNT_CPU;
      else if (gntCpu) lastGnt <= GNT_CPU;
      else if (gntExt) lastGnt <= GNT_EXT;
   end
`else
   localparam int CW = $clog2(MAX_WAIT + 1);

   logic [CW-1:0] waitCnt;

   dmem_arb_sel #(
      .MAX_WAIT (MAX_WAIT),
      .CW       (CW)
   ) uSel (
      .cpuReq  (cpuReqI),
      .extReq  (extReqI),
      .waitCnt (waitCnt),
      .gntCpu  (gntCpu),
      .gntExt  (gntExt)
   );

   // Count idle cycles in which a pending ext request is passed over.
   always_ff @(posedge clk) begin
      if (!rst)                      waitCnt <= '0;
      else if (!ext_valid || gntExt) waitCnt <= '0;
      else if (isIdle)               waitCnt <= waitCnt + CW'(1);
   end
`endif

   // Word address from the granted byte address; upper bits wrap.
   assign selAddr        = gntExt ? ext_addr : cpu_addr;
   assign mem_addr       = selAddr[AW:1];
   assign mem_wdata      = gntExt ? ext_wdata : cpu_wdata;
   assign unusedAddrBits = ^{selAddr[DATA_W-1:AW+1], selAddr[0]};

   // State register; reset abandons any in-flight read.
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= stateNext;
   end

   // Hold the last read data so the consumers see a stable value.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cpuRdataQ <= '0;
         extRdataQ <= '0;
      end else begin
         if (state == CPU_RD) cpuRdataQ <= mem_rdata;
         if (state == EXT_RD) extRdataQ <= mem_rdata;
      end
   end

   // Next state and handshake outputs; everything quiet during reset.
   always_comb begin
      stateNext  = state;
      cpu_stall  = 1'b0;
      ext_ready  = 1'b0;
      ext_rvalid = 1'b0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      cpu_rdata  = cpuRdataQ;
      ext_rdata  = extRdataQ;
      if (!rst) begin
         stateNext = IDLE;
         cpu_rdata = '0;
         ext_rdata = '0;
      end else begin
         unique case (state)
            IDLE: begin
               mem_en    = gntCpu || gntExt;
               mem_we    = (gntCpu && cpu_we) || (gntExt && ext_we);
               ext_ready = gntExt;
               cpu_stall = cpu_req && !(gntCpu && cpu_we);
               if (gntCpu && !cpu_we)      stateNext = CPU_RD;
               else if (gntExt && !ext_we) stateNext = EXT_RD;
            end
            CPU_RD: begin
               cpu_rdata = mem_rdata;
               stateNext = IDLE;
            end
            EXT_RD: begin
               ext_rvalid = 1'b1;
               ext_rdata  = mem_rdata;
               cpu_stall  = cpu_req;
               stateNext  = IDLE;
            end
            default: stateNext = IDLE;
         endcase
      end
   end

endmodule
